// File: rtl/uart_resp_pkg.sv
// Shared types and byte constants for the UART register responder.
// Holds the FSM state encoding and the ASCII command/reply set.
package uart_resp_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    GET_ADDR  = ST_GET_ADDR,
    GET_DATA  = ST_GET_DATA,
    SEND      = ST_SEND,
    WAIT_DONE = ST_WAIT_DONE
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_W   = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_R   = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_K   = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR = 8'h3F;

  // True when no bit at or above position abits is set in the address byte.
  function automatic logic addr_in_range(input logic [BYTE_W-1:0] b,
                                         input int unsigned abits);
    return (b >> abits) == '0;
  endfunction

endpackage

// File: rtl/uart_resp_regfile.sv
// Register file for the responder: async-reset array, one synchronous write
// port and two combinational read ports (command path and debug).
module uart_resp_regfile
  import uart_resp_pkg::*;
#(
  parameter int unsigned ADDR_BIT = 4,
  parameter int unsigned DW       = BYTE_W
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [ADDR_BIT-1:0] waddr_i,
  input  logic [DW-1:0]       wdata_i,
  input  logic [ADDR_BIT-1:0] raddr_a_i,
  output logic [DW-1:0]       rdata_a_o,
  input  logic [ADDR_BIT-1:0] raddr_b_i,
  output logic [DW-1:0]       rdata_b_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BIT;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/uart_reg_responder.sv
// Device-side command responder: parses 'W'/'R' host commands from uart_rx,
// accesses the register file and returns one reply byte through uart_tx.
module uart_reg_responder
  import uart_resp_pkg::*;
#(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned ADDR_BIT = 4,
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter int unsigned TO_BIT   = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done,
  input  logic [DBIT-1:0]     rx_data,
  input  logic                tx_done,
  output logic                tx_start,
  output logic [DBIT-1:0]     tx_data,
  input  logic [ADDR_BIT-1:0] dbg_addr,
  output logic [DBIT-1:0]     dbg_data,
  output logic                overrun
);

  state_e              state_q;
  logic [DBIT-1:0]     cmd_q;
  logic [ADDR_BIT-1:0] addr_q;
  logic [TO_BIT-1:0]   to_cnt_q;
  logic                tx_start_q;
  logic [DBIT-1:0]     tx_data_q;
  logic                overrun_q;

  logic [ADDR_BIT-1:0] rx_addr;
  logic                addr_ok;
  logic                wr_en;
  logic                timeout_hit;
  logic                busy;
  logic [DBIT-1:0]     rd_data;

  assign rx_addr     = rx_data[ADDR_BIT-1:0];
  assign addr_ok     = addr_in_range(BYTE_W'(rx_data), ADDR_BIT);
  assign wr_en       = (state_q == GET_DATA) && rx_done;
  assign timeout_hit = (to_cnt_q == TO_BIT'(TIMEOUT - 1));
  assign busy        = (state_q == SEND) || (state_q == WAIT_DONE);

  uart_resp_regfile #(
    .ADDR_BIT (ADDR_BIT),
    .DW       (DBIT)
  ) u_regfile (
    .clk       (clk),
    .rst_i     (reset),
    .we_i      (wr_en),
    .waddr_i   (addr_q),
    .wdata_i   (rx_data),
    .raddr_a_i (rx_addr),
    .rdata_a_o (rd_data),
    .raddr_b_i (dbg_addr),
    .rdata_b_o (dbg_data)
  );

  // Command FSM; rx_done takes priority over a same-cycle timeout expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      to_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (rx_done && busy) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (rx_done) begin
            cmd_q <= rx_data;
            if (rx_data == DBIT'(CMD_W) || rx_data == DBIT'(CMD_R)) begin
              state_q <= GET_ADDR;
            end else begin
              tx_data_q <= DBIT'(RSP_ERR);
              state_q   <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_done) begin
            to_cnt_q <= '0;
            addr_q   <= rx_addr;
            if (!addr_ok) begin
              tx_data_q <= DBIT'(RSP_ERR);
              state_q   <= SEND;
            end else if (cmd_q == DBIT'(CMD_R)) begin
              tx_data_q <= rd_data;
              state_q   <= SEND;
            end else begin
              state_q <= GET_DATA;
            end
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_BIT'(1);
          end
        end
        GET_DATA: begin
          if (rx_done) begin
            to_cnt_q  <= '0;
            tx_data_q <= DBIT'(RSP_K);
            state_q   <= SEND;
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_BIT'(1);
          end
        end
        SEND: begin
          tx_start_q <= 1'b1;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: a cycle-stamped command model
// predicts replies, a monitor checks every tx_start against the queue.
module tb_uart_reg_responder;

  localparam int TO     = 16;
  localparam int TX_LAT = 5;

  localparam logic [7:0] B_W   = 8'h57;
  localparam logic [7:0] B_R   = 8'h52;
  localparam logic [7:0] B_K   = 8'h4B;
  localparam logic [7:0] B_ERR = 8'h3F;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_done  = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       tx_done  = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] dbg_addr = 4'h0;
  logic [7:0] dbg_data;
  logic       overrun;

  uart_reg_responder #(
    .DBIT     (8),
    .ADDR_BIT (4),
    .TIMEOUT  (TO),
    .TO_BIT   (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] m_regs [16];
  logic [7:0] pend [$];
  int         last_cyc    = 0;
  int         busy_until  = -1000;
  logic       exp_overrun = 1'b0;
  exp_t       exp_q [$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_reply(input logic [7:0] v, input int c);
    exp_t e;
    e.data = v;
    e.cyc  = c + 2;
    exp_q.push_back(e);
    busy_until = c + 2 + TX_LAT;
    pend.delete();
  endtask

  // Byte on rx_done during cycle c: dropped while a reply is in flight,
  // otherwise appended to the command, after discarding a stale partial one.
  task automatic model_byte(input logic [7:0] b, input int c);
    if (c <= busy_until) begin
      exp_overrun = 1'b1;
      return;
    end
    if (pend.size() != 0 && (c - last_cyc) > TO) pend.delete();
    last_cyc = c;
    pend.push_back(b);
    if (pend[0] != B_W && pend[0] != B_R) begin
      push_reply(B_ERR, c);
    end else if (pend.size() == 2) begin
      if (pend[1] > 8'd15) push_reply(B_ERR, c);
      else if (pend[0] == B_R) push_reply(m_regs[pend[1]], c);
    end else if (pend.size() == 3) begin
      m_regs[pend[1]] = b;
      push_reply(B_K, c);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b, cyc);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_regs(input string nm);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      #1;
      chk(nm, 32'(dbg_data), 32'(m_regs[a]));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cyc <= busy_until + 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 500), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    for (int a = 0; a < 16; a++) m_regs[a] = 8'h00;
    pend.delete();
    exp_q.delete();
    busy_until  = -1000;
    exp_overrun = 1'b0;
    reset = 1'b0;
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    check_regs("reset_regs");
  endtask

  // Scoreboard monitor: every tx_start must match the oldest predicted reply.
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      chk("reply_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("reply_data", 32'(tx_data), 32'(e.data));
        chk("reply_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // uart_tx stand-in: tx_done TX_LAT cycles after tx_start.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (!reset && tx_start) begin
        d = tx_data;
        repeat (TX_LAT) @(negedge clk);
        tx_done = 1'b1;
        chk("tx_data_stable", 32'(tx_data), 32'(d));
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, expected finish before cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 16; a++) m_regs[a] = 8'h00;
    idle(3);
    do_reset();

    // Write then readback
    send_byte(B_W); idle(2); send_byte(8'h03); idle(1); send_byte(8'hA5);
    dbg_addr = 4'd3;
    #1;
    chk("write_visible", 32'(dbg_data), 32'hA5);
    drain();
    send_byte(B_R); send_byte(8'h03); drain();
    send_byte(B_R); idle(4); send_byte(8'h07); drain();

    // Unknown command and out-of-range address
    send_byte(8'h41); drain();
    send_byte(B_W); send_byte(8'h13); drain();
    check_regs("bad_addr_no_write");
    send_byte(B_R); send_byte(8'h03); drain();

    // Timeout expiry and a byte landing exactly on the expiry cycle
    send_byte(B_W); idle(TO);
    send_byte(B_R); send_byte(8'h00); drain();
    send_byte(B_W); idle(TO - 1); send_byte(8'h02); idle(TO - 1); send_byte(8'h5A); drain();
    check_regs("expiry_edge_write");

    // Byte dropped while a reply is in flight
    send_byte(B_R); send_byte(8'h03); idle(3); send_byte(8'h41); drain();
    chk("overrun_set", 32'(overrun), 32'(exp_overrun));
    send_byte(B_R); send_byte(8'h02); drain();
    chk("overrun_sticky", 32'(overrun), 32'(exp_overrun));

    // Reset while waiting for the data byte
    send_byte(B_W); send_byte(8'h05); idle(2);
    do_reset();
    send_byte(B_W); send_byte(8'h05); send_byte(8'h3C); drain();
    check_regs("write_after_reset");

    // Randomized traffic with random gaps
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      int r;
      if (pend.size() == 0 || (cyc - last_cyc) > TO) begin
        r = $urandom_range(0, 9);
        b = (r < 4) ? B_W : (r < 8) ? B_R : 8'($urandom);
      end else if (pend.size() == 1) begin
        b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      end else begin
        b = 8'($urandom);
      end
      send_byte(b);
      r = $urandom_range(0, 9);
      idle((r < 6) ? $urandom_range(0, 3) : $urandom_range(4, 20));
    end
    drain();
    chk("random_overrun", 32'(overrun), 32'(exp_overrun));
    check_regs("random_regs");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

- Command responder on the UART byte interface.
- Consumes received bytes (`rx_done`/`rx_data` from `uart_rx`) as host commands and reads/writes a 16-entry × 8-bit register file.
- Returns one response byte per command through `uart_tx` (`tx_start`/`tx_data`, completion on `tx_done`).
- Sits beside the baud generator and UART pair as the device-side end of the host link.

## Interface
Parameters:
- `DBIT`, 8, data bits per byte; the command byte set below assumes 8.
- `ADDR_BIT`, 4, register address width; register depth is 2^ADDR_BIT.
- `TIMEOUT`, 1_000_000, inter-byte timeout in clk cycles.
- `TO_BIT`, 20, timeout counter width.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `rx_done`  in  1  one-cycle pulse; `rx_data` valid
- `rx_data`  in  8  received byte
- `tx_done`  in  1  one-cycle pulse from `uart_tx` when the stop bit completes
- `tx_start`  out  1  one-cycle pulse requesting transmission
- `tx_data`  out  8  response byte; stable from `tx_start` until `tx_done`
- `dbg_addr`  in  ADDR_BIT  debug read address
- `dbg_data`  out  8  combinational `regs[dbg_addr]`
- `overrun`  out  1  sticky; set when a byte is dropped, cleared only by `reset`

## Operation
Protocol (ASCII):
- Write: `'W'`(0x57), addr, data → reply `'K'`(0x4B).
- Read: `'R'`(0x52), addr → reply `regs[addr]`.
- Any other first byte → reply `'?'`(0x3F).
- An addr byte with any bit above `ADDR_BIT-1` set → reply `'?'`. No write occurs; for a write command the data byte is not awaited.

States:
- IDLE: on `rx_done`, latch the command byte.
  - `'W'`/`'R'` → GET_ADDR.
  - Otherwise load `'?'` → SEND.
- GET_ADDR: on `rx_done`, latch the address.
  - Bad address → `'?'` → SEND.
  - `'R'` → load `regs[addr]` → SEND.
  - `'W'` → GET_DATA.
- GET_DATA: on `rx_done`, write `regs[addr] <= rx_data` in that cycle, load `'K'` → SEND.
- SEND: assert `tx_start` for exactly one cycle → WAIT_DONE.
- WAIT_DONE: on `tx_done` → IDLE.

Timeout and boundary rules:
- The timeout counter clears on every `rx_done` and on entry to GET_ADDR. It counts only in GET_ADDR/GET_DATA.
- When the count reaches `TIMEOUT-1` → IDLE, with no reply and no write.
- `rx_done` in the same cycle as timeout expiry: the byte is processed and the timeout is ignored.
- `rx_done` while in SEND/WAIT_DONE: byte dropped, `overrun` set.
- `tx_done` outside WAIT_DONE is ignored.
- Reset mid-operation: state → IDLE. Partial command discarded. A transmission already in flight in `uart_tx` is not aborted.

## Timing
Reset values:
- state IDLE, `tx_start` 0, `tx_data` 0x00, `overrun` 0, timeout counter 0.
- All registers 0x00, so `dbg_data` = 0x00.

Latency:
- `tx_start` pulses 2 cycles after the final command byte's `rx_done`: one cycle to register the state and load `tx_data`, one cycle in SEND.
- A register write is visible on `dbg_data` the cycle after the data byte's `rx_done`.
- A read in the same command sequence returns the updated value.

Outputs and counter:
- `tx_data` is registered and changes only when entering SEND.
- `tx_start` is registered and glitch-free.
- Timeout counter is `TO_BIT` wide and never wraps: it saturates at the expiry compare.

## Structure
- Package `uart_resp_pkg`:
  - state encoding localparams (IDLE, GET_ADDR, GET_DATA, SEND, WAIT_DONE);
  - command/reply byte constants `CMD_W`, `CMD_R`, `RSP_K`, `RSP_ERR`.
- Sub-module `uart_resp_regfile`: 2^ADDR_BIT × 8 registers, asynchronous reset to 0, one synchronous write port, two combinational read ports (FSM read, `dbg`).
- Top level: FSM, timeout counter, output registers.
- Top-level integration instantiates this block alongside the existing `uart_rx`, `uart_tx` and `mod_m_counter`. `tx_done` connects to `uart_tx`'s `tx_done_tick`.

## Test plan
Use a bench with a byte-level driver (`rx_done` pulses with arbitrary gaps) and a `tx_done` model 5 cycles after `tx_start`.
- Send 0x57,0x03,0xA5 → `'K'` on `tx_data` with one `tx_start` pulse 2 cycles after the last `rx_done`; `dbg_addr`=3 gives 0xA5.
- Then send 0x52,0x03 → reply 0xA5; then 0x52,0x07 → reply 0x00 (reset value).
- Send 0x41 → `'?'`. Send 0x57,0x13 → `'?'` after the address byte; no register changes; the next byte is parsed as a new command.
- Use `TIMEOUT`=16. Send 0x57, then idle 16 cycles → FSM back in IDLE, no `tx_start`. Then 0x52,0x00 → normal reply. Also send a byte exactly on the expiry cycle → it is accepted.
- Send a byte during WAIT_DONE → `overrun`=1, reply unaffected, the dropped byte is not parsed. `overrun` stays 1 until `reset`.
- Assert `reset` in GET_DATA → all outputs at reset values, registers cleared; the next full write command completes normally.
